// File: rtl/uart_pkg.sv
// Shared definitions for the UART link: receiver/transmitter state encodings
// and the default bit timing.
package uart_pkg;

   // Default serial bit period in system clock cycles
   localparam int CLKS_PER_BIT_DEFAULT = 217;

   // Frame-level states shared by the receiver and transmitter
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      START   = 3'd1,
      DATA    = 3'd2,
      STOP    = 3'd3,
      CLEANUP = 3'd4
   } uart_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Serial-in / byte-out bundle of the UART receiver.
// slave  : the receiver itself (consumes the line, produces byte and strobes)
// master : the pad / user-logic side (drives the line, observes byte and strobes)
interface uart_rx_if;

   logic       i_RX_Serial;
   logic       o_RX_DV;
   logic [7:0] o_RX_Byte;
   logic       o_RX_Active;
   logic       o_RX_Frame_Err;

   modport slave (
      input  i_RX_Serial,
      output o_RX_DV,
      output o_RX_Byte,
      output o_RX_Active,
      output o_RX_Frame_Err
   );

   modport master (
      output i_RX_Serial,
      input  o_RX_DV,
      input  o_RX_Byte,
      input  o_RX_Active,
      input  o_RX_Frame_Err
   );

endinterface

// File: rtl/uart_rx_sync2.sv
// Two-flop synchronizer for an asynchronous, idle-high input.
// Both flops reset to 1 so a reset never looks like a start bit.
module uart_sync2 (
   input  logic i_Clock,
   input  logic i_Rst_n,
   input  logic i_D,
   output logic o_Q
);

   logic r_Meta;
   logic r_Sync;

   // Shift the asynchronous input through two flops to settle metastability
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_Meta <= 1'b1;
         r_Sync <= 1'b1;
      end else begin
         r_Meta <= i_D;
         r_Sync <= r_Meta;
      end
   end

   assign o_Q = r_Sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Samples the synchronized line at mid-bit, reassembles
// the byte LSB first, and reports either a one-cycle data-valid strobe or a
// one-cycle framing-error strobe per frame. A low pulse shorter than half a
// bit is rejected as a glitch.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
)
(
   input  logic     i_Clock,
   input  logic     i_Rst_n,
   uart_rx_if.slave rx_if
);

   localparam int              CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0]   LAST_CNT = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0]   HALF_CNT = CW'((CLKS_PER_BIT - 1) / 2);

   logic        w_RX;

   uart_state_t r_State;
   uart_state_t w_State_Next;
   logic [CW-1:0] r_Cnt;
   logic [CW-1:0] w_Cnt_Next;
   logic [2:0]  r_Idx;
   logic [2:0]  w_Idx_Next;
   logic [7:0]  r_Shift;
   logic [7:0]  w_Shift_Next;
   logic [7:0]  r_Byte;
   logic [7:0]  w_Byte_Next;
   logic        r_DV;
   logic        w_DV_Next;
   logic        r_Err;
   logic        w_Err_Next;
   logic        r_Active;
   logic        w_Active_Next;

   uart_sync2 u_sync (
      .i_Clock (i_Clock),
      .i_Rst_n (i_Rst_n),
      .i_D     (rx_if.i_RX_Serial),
      .o_Q     (w_RX)
   );

   // State, counters, shift register and registered outputs
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_State  <= IDLE;
         r_Cnt    <= '0;
         r_Idx    <= '0;
         r_Shift  <= 8'h00;
         r_Byte   <= 8'h00;
         r_DV     <= 1'b0;
         r_Err    <= 1'b0;
         r_Active <= 1'b0;
      end else begin
         r_State  <= w_State_Next;
         r_Cnt    <= w_Cnt_Next;
         r_Idx    <= w_Idx_Next;
         r_Shift  <= w_Shift_Next;
         r_Byte   <= w_Byte_Next;
         r_DV     <= w_DV_Next;
         r_Err    <= w_Err_Next;
         r_Active <= w_Active_Next;
      end
   end

   // Next-state and next-output logic; strobes default low so they last one cycle
   always_comb begin
      w_State_Next  = r_State;
      w_Cnt_Next    = r_Cnt;
      w_Idx_Next    = r_Idx;
      w_Shift_Next  = r_Shift;
      w_Byte_Next   = r_Byte;
      w_DV_Next     = 1'b0;
      w_Err_Next    = 1'b0;
      w_Active_Next = r_Active;

      case (r_State)
         IDLE: begin
            w_Cnt_Next = '0;
            w_Idx_Next = '0;
            if (!w_RX) begin
               w_State_Next  = START;
               w_Active_Next = 1'b1;
            end
         end

         START: begin
            if (r_Cnt == HALF_CNT) begin
               w_Cnt_Next = '0;
               if (!w_RX) begin
                  w_State_Next = DATA;
               end else begin
                  w_State_Next  = IDLE;
                  w_Active_Next = 1'b0;
               end
            end else begin
               w_Cnt_Next = r_Cnt + 1'b1;
            end
         end

         DATA: begin
            if (r_Cnt == LAST_CNT) begin
               w_Cnt_Next          = '0;
               w_Shift_Next[r_Idx] = w_RX;
               if (r_Idx == 3'd7) begin
                  w_Idx_Next   = '0;
                  w_State_Next = STOP;
               end else begin
                  w_Idx_Next = r_Idx + 3'd1;
               end
            end else begin
               w_Cnt_Next = r_Cnt + 1'b1;
            end
         end

         STOP: begin
            if (r_Cnt == LAST_CNT) begin
               w_Cnt_Next    = '0;
               w_Active_Next = 1'b0;
               w_State_Next  = CLEANUP;
               if (w_RX) begin
                  w_Byte_Next = r_Shift;
                  w_DV_Next   = 1'b1;
               end else begin
                  w_Err_Next = 1'b1;
               end
            end else begin
               w_Cnt_Next = r_Cnt + 1'b1;
            end
         end

         CLEANUP: begin
            w_Cnt_Next    = '0;
            w_Active_Next = 1'b0;
            if (w_RX) begin
               w_State_Next = IDLE;
            end
         end

         default: begin
            w_State_Next  = IDLE;
            w_Cnt_Next    = '0;
            w_Idx_Next    = '0;
            w_Active_Next = 1'b0;
         end
      endcase
   end

   assign rx_if.o_RX_DV        = r_DV;
   assign rx_if.o_RX_Byte      = r_Byte;
   assign rx_if.o_RX_Active    = r_Active;
   assign rx_if.o_RX_Frame_Err = r_Err;

endmodule
